pipe_fetch_decode_skid: RTL and testbench
=========================================

Name: pipe_fetch_decode_skid

Overview:
- Parametrised fetch/decode pipeline register for the multithreaded core.
- Replaces the single-entry enable register with a 2-entry skid buffer and a full ready/valid handshake on both sides.
- Adds per-thread selective flush: a branch or exception squashes only the redirected thread's instructions.
- Sits between fetch (upstream) and decode (downstream). Decode backpressure never drops or duplicates an instruction.

Parameters:
- INST_WIDTH, 32: instruction word width.
- INST_ADDR_WIDTH, 9: PC width.
- TID_WIDTH, 2: thread-id width (2^TID_WIDTH hardware threads).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block accepts an instruction this cycle.
- inst_in  in  INST_WIDTH  fetched instruction.
- pc_in  in  INST_ADDR_WIDTH  PC of inst_in.
- tid_in  in  TID_WIDTH  thread of inst_in.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes this cycle.
- inst_out  out  INST_WIDTH  instruction to decode.
- pc_out  out  INST_ADDR_WIDTH  PC to decode.
- tid_out  out  TID_WIDTH  thread to decode.
- flush  in  1  squash every instruction of thread flush_tid.
- flush_tid  in  TID_WIDTH  thread being squashed.
- flush_all  in  1  squash everything.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Storage: two slots, each holding {valid, inst, pc, tid}:
  - main drives the outputs.
  - skid holds the overflow entry.
- Outputs:
  - out_valid = main.valid.
  - inst_out, pc_out and tid_out are registered from main.
  - in_ready = !skid.valid && !reset. It is a function of registers only; there is no combinational in_ready path from out_ready.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when main is empty or being consumed. Sustained throughput is 1 per cycle.
- Ordering: strict FIFO. skid is always older than any new accept. When main empties, skid moves to main before any incoming entry.
- Per-cycle update with no flush:
  - Main empty or consumed, skid empty: an accept loads main directly; otherwise main.valid is cleared.
  - Main empty or consumed, skid full: skid moves to main and skid is cleared. Accept is impossible because in_ready = 0.
  - Main held (valid && !out_ready): an accept loads skid.
- Flush in the same cycle (flush with flush_tid, or flush_all):
  - Any resident slot whose tid matches, or every slot under flush_all, is invalidated before the movement rules apply.
  - An accepted beat whose tid matches is discarded. in_ready is still 1 for it, so fetch sees it as taken.
  - A consume in the flush cycle still counts, because decode already sampled main. A flush therefore only affects the state of the following cycle.
  - After invalidation, a surviving skid entry compacts into main.
  - flush_all dominates flush.
- Data hold: when main.valid = 0, inst_out, pc_out and tid_out keep their last values. Decode must qualify them with out_valid.
- Reset values:
  - out_valid = 0, skid.valid = 0, in_ready = 0 while reset is asserted.
  - inst_out = 0, pc_out = 0, tid_out = 0.
  - Reset mid-transfer discards both slots; no beat is accepted in the reset cycle.
- X rules: inst_in, pc_in and tid_in are don't-care when in_valid = 0. flush_tid is don't-care when flush = 0.

Decomposition:
- Package arya_pipe_pkg holds:
  - default widths (INST_WIDTH, INST_ADDR_WIDTH, TID_WIDTH);
  - a NOP instruction constant (all zeros) for the reset value;
  - a packed struct type {valid, inst, pc, tid} for a pipeline slot.
- Sub-module pipe_slot holds one slot register with these controls:
  - load with data;
  - clear valid;
  - a tid-match flush-compare output.
- Instantiate pipe_slot twice (main and skid). Handshake and move control stays in the top level.

Test Plan:
- Streaming: after reset, out_ready = 1 and in_valid = 1 for 8 cycles with pc 0..7 -> outputs pc 0..7 on consecutive cycles starting 1 cycle after the first accept. in_ready stays 1 throughout.
- Backpressure: hold out_ready = 0 while sending pc 0x10, 0x11, 0x12 ->
  - 0x10 in main, 0x11 in skid, in_ready drops to 0, 0x12 is held by fetch;
  - release out_ready -> 0x10, 0x11, 0x12 delivered in order with none lost or duplicated.
- Selective flush: main holds tid 1 / pc 0x20, skid holds tid 2 / pc 0x21, out_ready = 0. Pulse flush with flush_tid = 1 -> next cycle out_valid = 1 with pc 0x21, tid 2, and skid empty.
- Flush of incoming: skid empty, accept tid 3 / pc 0x30 in the same cycle as flush with flush_tid = 3 -> pc 0x30 never appears on the outputs.
- flush_all with both slots full and in_valid = 1 -> out_valid = 0 and in_ready = 1 the next cycle.
- Reset mid-stream: assert reset with both slots full -> the following cycle out_valid = 0, inst_out = 0, pc_out = 0, tid_out = 0, and in_ready = 0 while reset is high.

Source files
------------

// File: rtl/pipe_fetch_decode_skid_pkg.sv
// arya_pipe_pkg: default widths, reset NOP and slot layout for the fetch/decode pipe
package arya_pipe_pkg;
  localparam int INST_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 9;
  localparam int TID_WIDTH = 2;
  localparam logic [INST_WIDTH-1:0] NOP_INST = '0;
  typedef struct packed {
    logic                       valid;
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [TID_WIDTH-1:0]       tid;
  } slot_t;
endpackage

// File: rtl/pipe_fetch_decode_skid_slot.sv
// pipe_slot: one pipeline slot register with load, valid-clear and thread match
module pipe_slot
  import arya_pipe_pkg::*;
#(
  parameter int IW = INST_WIDTH,
  parameter int AW = INST_ADDR_WIDTH,
  parameter int TW = TID_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clr,
  input  logic [IW-1:0] d_inst,
  input  logic [AW-1:0] d_pc,
  input  logic [TW-1:0] d_tid,
  input  logic [TW-1:0] cmp_tid,
  output logic          valid,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] pc,
  output logic [TW-1:0] tid,
  output logic          match
);
  logic          valid_q, valid_d;
  logic [IW-1:0] inst_q, inst_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [TW-1:0] tid_q, tid_d;
  // payload only changes on load so a cleared slot keeps its last contents
  always_comb begin
    valid_d = load ? 1'b1 : (clr ? 1'b0 : valid_q);
    inst_d  = load ? d_inst : inst_q;
    pc_d    = load ? d_pc : pc_q;
    tid_d   = load ? d_tid : tid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      inst_q  <= IW'(NOP_INST);
      pc_q    <= '0;
      tid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      tid_q   <= tid_d;
    end
  end
  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;
  assign tid   = tid_q;
  assign match = valid_q && (tid_q == cmp_tid);
endmodule

// File: rtl/pipe_fetch_decode_skid.sv
// pipe_fetch_decode_skid: 2-entry skid buffer between fetch and decode with per-thread flush
module pipe_fetch_decode_skid
  import arya_pipe_pkg::*;
#(
  parameter int INST_WIDTH      = arya_pipe_pkg::INST_WIDTH,
  parameter int INST_ADDR_WIDTH = arya_pipe_pkg::INST_ADDR_WIDTH,
  parameter int TID_WIDTH       = arya_pipe_pkg::TID_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_WIDTH-1:0]      inst_in,
  input  logic [INST_ADDR_WIDTH-1:0] pc_in,
  input  logic [TID_WIDTH-1:0]       tid_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [TID_WIDTH-1:0]       tid_out,
  input  logic                       flush,
  input  logic [TID_WIDTH-1:0]       flush_tid,
  input  logic                       flush_all
);
  logic                       main_v, main_m, skid_v, skid_m;
  logic [INST_WIDTH-1:0]      skid_inst;
  logic [INST_ADDR_WIDTH-1:0] skid_pc;
  logic [TID_WIDTH-1:0]       skid_tid;
  logic                       main_kill, skid_kill, skid_live, acc, acc_keep, main_free;
  logic                       main_load, main_from_skid, main_clr, skid_load, skid_clr;
  logic [INST_WIDTH-1:0]      main_inst_d;
  logic [INST_ADDR_WIDTH-1:0] main_pc_d;
  logic [TID_WIDTH-1:0]       main_tid_d;
  assign in_ready = !skid_v && !reset;
  // a consume in a flush cycle still frees main since decode already sampled it
  always_comb begin
    main_kill      = main_v && (flush_all || (flush && main_m));
    skid_kill      = skid_v && (flush_all || (flush && skid_m));
    skid_live      = skid_v && !skid_kill;
    acc            = in_valid && in_ready;
    acc_keep       = acc && !flush_all && !(flush && tid_in == flush_tid);
    main_free      = !main_v || out_ready || main_kill;
    main_from_skid = main_free && skid_live;
    main_load      = main_from_skid || (main_free && acc_keep);
    main_clr       = main_free && !main_load;
    skid_load      = !main_free && !skid_live && acc_keep;
    skid_clr       = main_free || !skid_live;
    main_inst_d    = main_from_skid ? skid_inst : inst_in;
    main_pc_d      = main_from_skid ? skid_pc : pc_in;
    main_tid_d     = main_from_skid ? skid_tid : tid_in;
  end
  pipe_slot #(.IW(INST_WIDTH), .AW(INST_ADDR_WIDTH), .TW(TID_WIDTH)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clr(main_clr),
    .d_inst(main_inst_d), .d_pc(main_pc_d), .d_tid(main_tid_d), .cmp_tid(flush_tid),
    .valid(main_v), .inst(inst_out), .pc(pc_out), .tid(tid_out), .match(main_m)
  );
  pipe_slot #(.IW(INST_WIDTH), .AW(INST_ADDR_WIDTH), .TW(TID_WIDTH)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clr(skid_clr),
    .d_inst(inst_in), .d_pc(pc_in), .d_tid(tid_in), .cmp_tid(flush_tid),
    .valid(skid_v), .inst(skid_inst), .pc(skid_pc), .tid(skid_tid), .match(skid_m)
  );
  assign out_valid = main_v;
endmodule

// File: tb/tb_pipe_fetch_decode_skid.sv
// tb_pipe_fetch_decode_skid: directed checks of streaming, backpressure, flush and reset
module tb_pipe_fetch_decode_skid;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, flush, flush_all;
  logic [31:0] inst_in, inst_out;
  logic [8:0]  pc_in, pc_out;
  logic [1:0]  tid_in, tid_out, flush_tid;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  pipe_fetch_decode_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .tid_in(tid_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .pc_out(pc_out), .tid_out(tid_out),
    .flush(flush), .flush_tid(flush_tid), .flush_all(flush_all)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic v, input logic [8:0] pc, input logic [1:0] tid);
    in_valid = v;
    pc_in    = pc;
    tid_in   = tid;
    inst_in  = 32'hA500_0000 | {23'h0, pc};
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; out_ready = 1'b0; flush = 1'b0; flush_tid = 2'd0; flush_all = 1'b0;
    send(1'b1, 9'h1ff, 2'd3);
    tick;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_pc", {23'h0, pc_out}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    send(1'b0, 9'd0, 2'd0);
    #1;
    chk("idle_in_ready", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 9'(i), 2'(i));
      tick;
      chk("stream_valid", {31'h0, out_valid}, 32'd1);
      chk("stream_pc", {23'h0, pc_out}, i);
      chk("stream_inst", inst_out, 32'hA500_0000 | i);
      chk("stream_tid", {30'h0, tid_out}, i % 4);
      chk("stream_ready", {31'h0, in_ready}, 32'd1);
    end
    send(1'b0, 9'd0, 2'd0);
    tick;
    chk("stream_drain", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(1'b1, 9'h10, 2'd0);
    tick;
    chk("bp_main", {23'h0, pc_out}, 32'h10);
    chk("bp_rdy1", {31'h0, in_ready}, 32'd1);
    send(1'b1, 9'h11, 2'd0);
    tick;
    chk("bp_full_rdy", {31'h0, in_ready}, 32'd0);
    chk("bp_full_pc", {23'h0, pc_out}, 32'h10);
    send(1'b1, 9'h12, 2'd0);
    tick;
    chk("bp_hold_pc", {23'h0, pc_out}, 32'h10);
    chk("bp_hold_rdy", {31'h0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick;
    chk("bp_rel_pc11", {23'h0, pc_out}, 32'h11);
    chk("bp_rel_rdy", {31'h0, in_ready}, 32'd1);
    tick;
    chk("bp_rel_pc12", {23'h0, pc_out}, 32'h12);
    chk("bp_rel_v12", {31'h0, out_valid}, 32'd1);
    send(1'b0, 9'd0, 2'd0);
    tick;
    chk("bp_empty", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(1'b1, 9'h20, 2'd1);
    tick;
    send(1'b1, 9'h21, 2'd2);
    tick;
    chk("sf_skid_full", {31'h0, in_ready}, 32'd0);
    send(1'b0, 9'd0, 2'd0);
    flush = 1'b1; flush_tid = 2'd1;
    tick;
    flush = 1'b0;
    chk("sf_valid", {31'h0, out_valid}, 32'd1);
    chk("sf_pc", {23'h0, pc_out}, 32'h21);
    chk("sf_tid", {30'h0, tid_out}, 32'd2);
    chk("sf_skid_empty", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick;
    chk("sf_drain", {31'h0, out_valid}, 32'd0);
    send(1'b1, 9'h30, 2'd3);
    flush = 1'b1; flush_tid = 2'd3;
    #1;
    chk("fi_taken", {31'h0, in_ready}, 32'd1);
    tick;
    flush = 1'b0;
    send(1'b0, 9'd0, 2'd0);
    chk("fi_valid", {31'h0, out_valid}, 32'd0);
    chk("fi_hold_pc", {23'h0, pc_out}, 32'h21);
    tick;
    chk("fi_valid2", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(1'b1, 9'h38, 2'd0);
    flush = 1'b1; flush_tid = 2'd3;
    tick;
    flush = 1'b0;
    chk("fo_other_tid", {23'h0, pc_out}, 32'h38);
    send(1'b1, 9'h39, 2'd1);
    flush = 1'b1; flush_tid = 2'd0;
    tick;
    flush = 1'b0;
    send(1'b0, 9'd0, 2'd0);
    chk("fm_compact_pc", {23'h0, pc_out}, 32'h39);
    chk("fm_compact_rdy", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    send(1'b1, 9'h40, 2'd0);
    tick;
    send(1'b1, 9'h41, 2'd1);
    tick;
    send(1'b1, 9'h42, 2'd2);
    flush_all = 1'b1; flush = 1'b1; flush_tid = 2'd3;
    tick;
    flush_all = 1'b0; flush = 1'b0;
    chk("fa_valid", {31'h0, out_valid}, 32'd0);
    chk("fa_ready", {31'h0, in_ready}, 32'd1);
    send(1'b1, 9'h60, 2'd1);
    tick;
    send(1'b1, 9'h61, 2'd2);
    tick;
    chk("rm_full", {31'h0, in_ready}, 32'd0);
    chk("rm_pc", {23'h0, pc_out}, 32'h60);
    reset = 1'b1;
    #1;
    chk("rm_rdy_in_reset", {31'h0, in_ready}, 32'd0);
    tick;
    chk("rm_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rm_inst", inst_out, 32'd0);
    chk("rm_pc0", {23'h0, pc_out}, 32'd0);
    chk("rm_tid", {30'h0, tid_out}, 32'd0);
    chk("rm_rdy_hi", {31'h0, in_ready}, 32'd0);
    reset = 1'b0;
    send(1'b0, 9'd0, 2'd0);
    tick;
    chk("rm_after_valid", {31'h0, out_valid}, 32'd0);
    chk("rm_after_rdy", {31'h0, in_ready}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
